noc_packet_receiver: RTL

NOC_PACKET_RECEIVER -- requirements
Module: noc_packet_receiver

---
 rtl/noc_pkg.sv | 13 +
 rtl/noc_flit_buffer.sv | 26 ++
 rtl/noc_packet_receiver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared defaults and state encoding for the NoC packet receiver.
package noc_pkg;

    localparam int DEFAULT_DATA_WIDTH       = 32;
    localparam int DEFAULT_FLITS_PER_PACKET = 6;
    localparam int DEFAULT_DEST_WIDTH       = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        DELIVER = 1'b1
    } rx_state_t;

endpackage

// File: rtl/noc_flit_buffer.sv
// Packet buffer: one write port (flit side) and one asynchronous read port (core side).
module noc_flit_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 6,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Combinational read so the first flit is presented in the cycle DELIVER starts.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/noc_packet_receiver.sv
// Collects a full packet from the router, then delivers it to the core if addressed here.
// Optional packet/misroute counters are built when NOC_RX_PKT_CNT_EN is defined.
module noc_packet_receiver
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int FLITS_PER_PACKET = DEFAULT_FLITS_PER_PACKET,
    parameter int DEST_WIDTH       = DEFAULT_DEST_WIDTH,
    parameter int NODE_ID          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] flit_data_in,
    input  logic                  flit_valid_in,
    output logic                  flit_ready_out,
    output logic [DATA_WIDTH-1:0] pkt_data_out,
    output logic                  pkt_valid_out,
    output logic                  pkt_sop_out,
    output logic                  pkt_eop_out,
    input  logic                  pkt_ready_in
`ifdef NOC_RX_PKT_CNT_EN
    ,
    output logic [15:0]           rx_pkt_count,
    output logic [15:0]           misroute_count
`endif
);

    localparam int IDX_W = (FLITS_PER_PACKET > 2) ? $clog2(FLITS_PER_PACKET) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(FLITS_PER_PACKET - 1);
    localparam logic [DEST_WIDTH-1:0] LOCAL_DEST = DEST_WIDTH'(NODE_ID);

    rx_state_t             state_reg, state_next;
    logic [IDX_W-1:0]      wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0]      rd_idx_reg, rd_idx_next;
    logic [DEST_WIDTH-1:0] dest_reg, dest_next;
    logic                  flit_xfer;
    logic                  pkt_xfer;
    logic [DATA_WIDTH-1:0] rd_data;

    // Gating with rst keeps the router side stalled while reset is held.
    assign flit_ready_out = rst && (state_reg == COLLECT);
    assign pkt_valid_out  = (state_reg == DELIVER);
    assign flit_xfer      = flit_valid_in && flit_ready_out;
    assign pkt_xfer       = pkt_valid_out && pkt_ready_in;
    assign pkt_data_out   = pkt_valid_out ? rd_data : '0;
    assign pkt_sop_out    = pkt_valid_out && (rd_idx_reg == '0);
    assign pkt_eop_out    = pkt_valid_out && (rd_idx_reg == LAST_IDX);

    noc_flit_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FLITS_PER_PACKET),
        .IDX_W      (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (flit_xfer),
        .wr_idx  (wr_idx_reg),
        .wr_data (flit_data_in),
        .rd_idx  (rd_idx_reg),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= COLLECT;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            dest_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            dest_reg   <= dest_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        dest_next   = dest_reg;
        case (state_reg)
            COLLECT: begin
                if (flit_xfer) begin
                    if (wr_idx_reg == '0) begin
                        dest_next = flit_data_in[DEST_WIDTH-1:0];
                    end
                    if (wr_idx_reg == LAST_IDX) begin
                        // Header was captured earlier, so dest_reg is valid on the last flit.
                        wr_idx_next = '0;
                        if (dest_reg == LOCAL_DEST) begin
                            state_next = DELIVER;
                        end
                    end else begin
                        wr_idx_next = wr_idx_reg + IDX_W'(1);
                    end
                end
            end
            DELIVER: begin
                if (pkt_xfer) begin
                    if (rd_idx_reg == LAST_IDX) begin
                        rd_idx_next = '0;
                        state_next  = COLLECT;
                    end else begin
                        rd_idx_next = rd_idx_reg + IDX_W'(1);
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

`ifdef NOC_RX_PKT_CNT_EN
    logic        rx_done;
    logic        misroute;
    logic [15:0] rx_cnt_reg;
    logic [15:0] mis_cnt_reg;

    assign rx_done  = pkt_xfer && (rd_idx_reg == LAST_IDX);
    assign misroute = flit_xfer && (wr_idx_reg == LAST_IDX) && (dest_reg != LOCAL_DEST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt_reg  <= '0;
            mis_cnt_reg <= '0;
        end else begin
            if (rx_done && (rx_cnt_reg != 16'hFFFF)) begin
                rx_cnt_reg <= rx_cnt_reg + 16'd1;
            end
            if (misroute && (mis_cnt_reg != 16'hFFFF)) begin
                mis_cnt_reg <= mis_cnt_reg + 16'd1;
            end
        end
    end

    assign rx_pkt_count   = rx_cnt_reg;
    assign misroute_count = mis_cnt_reg;
`endif

endmodule
